ahb2_bus_nslv: RTL and testbench
================================

AHB2_BUS_NSLV -- requirements
Module: ahb2_bus_nslv

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4: number of AHB2 slave ports, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, 32 or 64.
REQ-004 SHALL have parameter SLV_BASE, default {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: per-slave base addresses, packed NUM_SLV*ADDR_W.
REQ-005 SHALL have parameter SLV_MASK, default all 32'hF000_0000: per-slave decode masks, packed NUM_SLV*ADDR_W.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have master inputs m_haddr (ADDR_W), m_htrans (2), m_hwrite (1), m_hsize (3), m_hburst (3), m_hprot (4), m_hwdata (DATA_W).
REQ-009 SHALL have master outputs m_hgrant (1), m_hrdata (DATA_W), m_hresp (2), m_hready (1).
REQ-010 SHALL have port s_hsel, output, NUM_SLV bits: one-hot slave select.
REQ-011 SHALL have broadcast outputs s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata, each the same width as its master counterpart.
REQ-012 SHALL have port s_hreadyi, output, 1 bit: bus HREADY fed back to every slave.
REQ-013 SHALL have slave inputs s_hrdata (NUM_SLV*DATA_W), s_hresp (NUM_SLV*2), s_hreadyo (NUM_SLV).
REQ-014 SHALL have port err_cnt, output, 16 bits: saturating count of decode errors.
REQ-015 SHALL have port err_addr, output, ADDR_W bits: address of the most recent decode error.

Function
REQ-016 SHALL tie m_hgrant to 1.
REQ-017 SHALL drive every broadcast signal to its m_* source combinationally, with zero latency.
REQ-018 SHALL decode slave i as hit when (m_haddr & SLV_MASK[i]) == SLV_BASE[i]; on overlapping hits the lowest index wins.
REQ-019 SHALL drive s_hsel combinationally from the decode irrespective of m_htrans; s_hsel is all-zero on a miss.
REQ-020 SHALL hold a data-phase owner register (NONE, SLV[i], DEFAULT) that updates only on cycles where m_hready=1.
REQ-021 SHALL load the owner register as follows: m_htrans NONSEQ/SEQ with a hit loads SLV[i]; NONSEQ/SEQ with a miss loads DEFAULT; IDLE/BUSY loads NONE.
REQ-022 SHALL, when the owner is NONE, drive m_hready=1, m_hresp=OKAY(00), m_hrdata=0.
REQ-023 SHALL, when the owner is SLV[i], drive m_hready/m_hresp/m_hrdata from s_hreadyo[i]/s_hresp[i]/s_hrdata[i].
REQ-024 SHALL drive s_hreadyi equal to m_hready at all times.
REQ-025 SHALL run a default-slave FSM with states IDLE, ERR1, ERR2.
- IDLE->ERR1 when the owner register loads DEFAULT.
- ERR1->ERR2 unconditionally.
- ERR2->IDLE, or ERR2->ERR1 if DEFAULT is loaded again.
REQ-026 SHALL, in FSM state ERR1, drive m_hready=0, m_hresp=ERROR(01), m_hrdata=0.
REQ-027 SHALL, in FSM state ERR2, drive m_hready=1, m_hresp=ERROR(01), m_hrdata=0.
REQ-028 SHALL, on every load of DEFAULT, increment err_cnt (saturating at 16'hFFFF) and capture m_haddr into err_addr in the same edge.
REQ-029 SHALL complete a slave wait-state sequence (s_hreadyo=0) or a RETRY/SPLIT two-cycle response before accepting a new owner, because the owner register holds while m_hready=0.
REQ-030 SHALL, with NUM_SLV=1, reduce to a pass-through of slave 0 when SLV_MASK=0.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronous assert), force owner=NONE, FSM=IDLE, err_cnt=0, err_addr=0, and therefore m_hready=1, m_hresp=OKAY, m_hrdata=0.
REQ-032 SHALL abandon any in-flight data phase on reset assertion mid-transfer and resume on the first rising edge after rst_n deasserts.

Verification
REQ-033 Bench SHALL cover: NONSEQ read 0x2000_0010 -> s_hsel=4'b0100; next cycle m_hrdata = s_hrdata[2], m_hresp=OKAY.
REQ-034 Bench SHALL cover: write to slave 1 with s_hreadyo[1]=0 for 3 cycles -> m_hready=0 for 3 cycles; owner held; next address phase not decoded into owner.
REQ-035 Bench SHALL cover: NONSEQ to 0x5000_0000 (miss) -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01); err_cnt=1, err_addr=0x5000_0000.
REQ-036 Bench SHALL cover: IDLE transfer to an unmapped address -> zero-wait OKAY; err_cnt unchanged.
REQ-037 Bench SHALL cover: back-to-back misses, then a hit in the ERR2 cycle -> ERR1 re-entered or slave owner taken correctly; err_cnt increments per miss; saturation holds at 16'hFFFF after a preload.
REQ-038 Bench SHALL cover: rst_n asserted during ERR1 -> m_hready=1, m_hresp=00, err_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/ahb2_bus_nslv.sv
// Single-master AHB2 interconnect: address decode to NUM_SLV slaves, data-phase response mux,
// and a built-in default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb2_bus_nslv #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           m_haddr,
    input  logic [1:0]                  m_htrans,
    input  logic                        m_hwrite,
    input  logic [2:0]                  m_hsize,
    input  logic [2:0]                  m_hburst,
    input  logic [3:0]                  m_hprot,
    input  logic [DATA_W-1:0]           m_hwdata,
    output logic                        m_hgrant,
    output logic [DATA_W-1:0]           m_hrdata,
    output logic [1:0]                  m_hresp,
    output logic                        m_hready,
    output logic [NUM_SLV-1:0]          s_hsel,
    output logic [ADDR_W-1:0]           s_haddr,
    output logic [1:0]                  s_htrans,
    output logic                        s_hwrite,
    output logic [2:0]                  s_hsize,
    output logic [2:0]                  s_hburst,
    output logic [3:0]                  s_hprot,
    output logic [DATA_W-1:0]           s_hwdata,
    output logic                        s_hreadyi,
    input  logic [NUM_SLV*DATA_W-1:0]   s_hrdata,
    input  logic [NUM_SLV*2-1:0]        s_hresp,
    input  logic [NUM_SLV-1:0]          s_hreadyo,
    output logic [15:0]                 err_cnt,
    output logic [ADDR_W-1:0]           err_addr
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {OwnNone, OwnSlv, OwnDflt} owner_e;
    typedef enum logic [1:0] {StIdle, StErr1, StErr2} dflt_state_e;

    owner_e             owner_q, owner_d;
    logic [IDX_W-1:0]   owner_idx_q, owner_idx_d;
    dflt_state_e        state_q, state_d;
    logic [15:0]        err_cnt_q;
    logic [ADDR_W-1:0]  err_addr_q;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               active;
    logic               load_dflt;
    logic               hready;
    logic [1:0]         hresp;
    logic [DATA_W-1:0]  hrdata;

    assign m_hgrant  = 1'b1;
    assign s_haddr   = m_haddr;
    assign s_htrans  = m_htrans;
    assign s_hwrite  = m_hwrite;
    assign s_hsize   = m_hsize;
    assign s_hburst  = m_hburst;
    assign s_hprot   = m_hprot;
    assign s_hwdata  = m_hwdata;

    // Descending scan so the lowest matching index is the last to write.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((m_haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        s_hsel = hit ? (NUM_SLV'(1) << hit_idx) : '0;
    end

    assign active    = m_htrans[1];
    assign load_dflt = hready & active & ~hit;

    always_comb begin
        owner_d     = owner_q;
        owner_idx_d = owner_idx_q;
        if (hready) begin
            if (!active) begin
                owner_d = OwnNone;
            end else if (hit) begin
                owner_d     = OwnSlv;
                owner_idx_d = hit_idx;
            end else begin
                owner_d = OwnDflt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (load_dflt) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = load_dflt ? StErr1 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 2'b00;
        hrdata = '0;
        case (owner_q)
            OwnSlv: begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (owner_idx_q == IDX_W'(i)) begin
                        hready = s_hreadyo[i];
                        hresp  = s_hresp[2*i +: 2];
                        hrdata = s_hrdata[i*DATA_W +: DATA_W];
                    end
                end
            end
            OwnDflt: begin
                hready = (state_q != StErr1);
                hresp  = 2'b01;
            end
            default: ;
        endcase
    end

    assign m_hready  = hready;
    assign m_hresp   = hresp;
    assign m_hrdata  = hrdata;
    assign s_hreadyi = hready;
    assign err_cnt   = err_cnt_q;
    assign err_addr  = err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OwnNone;
            owner_idx_q <= '0;
            state_q     <= StIdle;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            owner_idx_q <= owner_idx_d;
            state_q     <= state_d;
            if (load_dflt) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                err_addr_q <= m_haddr;
            end
        end
    end

endmodule

// File: tb/tb_ahb2_bus_nslv.sv
// Scoreboard bench for ahb2_bus_nslv: data-phase expectations are queued as address phases
// are accepted and checked when the corresponding data phase completes.
module tb_ahb2_bus_nslv;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic         clk;
    logic         rst_n;
    logic [31:0]  m_haddr;
    logic [1:0]   m_htrans;
    logic         m_hwrite;
    logic [2:0]   m_hsize;
    logic [2:0]   m_hburst;
    logic [3:0]   m_hprot;
    logic [31:0]  m_hwdata;
    logic         m_hgrant;
    logic [31:0]  m_hrdata;
    logic [1:0]   m_hresp;
    logic         m_hready;
    logic [3:0]   s_hsel;
    logic [31:0]  s_haddr;
    logic [1:0]   s_htrans;
    logic         s_hwrite;
    logic [2:0]   s_hsize;
    logic [2:0]   s_hburst;
    logic [3:0]   s_hprot;
    logic [31:0]  s_hwdata;
    logic         s_hreadyi;
    logic [127:0] s_hrdata;
    logic [7:0]   s_hresp;
    logic [3:0]   s_hreadyo;
    logic [15:0]  err_cnt;
    logic [31:0]  err_addr;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks;
    int          fails;
    logic [15:0] exp_cnt;

    ahb2_bus_nslv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_haddr   (m_haddr),
        .m_htrans  (m_htrans),
        .m_hwrite  (m_hwrite),
        .m_hsize   (m_hsize),
        .m_hburst  (m_hburst),
        .m_hprot   (m_hprot),
        .m_hwdata  (m_hwdata),
        .m_hgrant  (m_hgrant),
        .m_hrdata  (m_hrdata),
        .m_hresp   (m_hresp),
        .m_hready  (m_hready),
        .s_hsel    (s_hsel),
        .s_haddr   (s_haddr),
        .s_htrans  (s_htrans),
        .s_hwrite  (s_hwrite),
        .s_hsize   (s_hsize),
        .s_hburst  (s_hburst),
        .s_hprot   (s_hprot),
        .s_hwdata  (s_hwdata),
        .s_hreadyi (s_hreadyi),
        .s_hrdata  (s_hrdata),
        .s_hresp   (s_hresp),
        .s_hreadyo (s_hreadyo),
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    function automatic logic [31:0] slv_data(input int i);
        return 32'hD000_005A | (32'(i) << 8);
    endfunction

    // Reference map: slave n lives at n<<28 for n in 0..3, everything else is unmapped.
    function automatic exp_t exp_for(input logic [31:0] a, input logic [1:0] t);
        exp_t r;
        r.resp  = 2'b00;
        r.rdata = '0;
        if (t[1]) begin
            if (a[31:28] < 4'd4) r.rdata = slv_data(int'(a[31:28]));
            else                 r.resp  = 2'b01;
        end
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
        @(posedge clk);
        #1;
        m_haddr  = a;
        m_htrans = t;
        m_hwrite = w;
        m_hwdata = a ^ 32'h5555_5555;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({m_hgrant, m_hready, m_hresp, m_hrdata, err_cnt, err_addr} !== {2'b11, 2'b00, 80'h0}) begin
            fails++;
            $display("FAIL reset_state: got grant=%b ready=%b resp=%b rdata=%h cnt=%h addr=%h, expected 1 1 00 0 0 0",
                     m_hgrant, m_hready, m_hresp, m_hrdata, err_cnt, err_addr);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({m_hready, s_hreadyi, m_hresp} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_release: got ready=%b readyi=%b resp=%b, expected 1 1 00",
                     m_hready, s_hreadyi, m_hresp);
        end
    endtask

    task automatic test_read_hit();
        drive(32'h2000_0010, NONSEQ, 1'b0);
        @(negedge clk);
        checks++;
        if (s_hsel !== 4'b0100) begin
            fails++;
            $display("FAIL read_hsel: got %b, expected 0100", s_hsel);
        end
        checks++;
        if ({s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata} !==
            {m_haddr, NONSEQ, 1'b0, 3'b010, 3'b000, 4'b0011, 32'h7555_5545}) begin
            fails++;
            $display("FAIL broadcast: got addr=%h trans=%b wdata=%h, expected 20000010 10 75555545",
                     s_haddr, s_htrans, s_hwdata);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL read_data: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
    endtask

    task automatic test_wait_states();
        drive(32'h1000_0040, NONSEQ, 1'b1);
        @(negedge clk);
        checks++;
        if (s_hsel !== 4'b0010) begin
            fails++;
            $display("FAIL write_hsel: got %b, expected 0010", s_hsel);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h2000_0020, NONSEQ, 1'b0);
        s_hreadyo[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({m_hready, s_hreadyi} !== 2'b00) begin
                fails++;
                $display("FAIL wait_state_%0d: got ready=%b readyi=%b, expected 0 0",
                         k, m_hready, s_hreadyi);
            end
            next_cycle();
            if (k == 2) s_hreadyo[1] = 1'b1;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL write_done: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL held_phase_read: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
    endtask

    task automatic test_miss();
        drive(32'h5000_0000, NONSEQ, 1'b0);
        @(negedge clk);
        checks++;
        if (s_hsel !== 4'b0000) begin
            fails++;
            $display("FAIL miss_hsel: got %b, expected 0000", s_hsel);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b0, 2'b01, 32'h0}) begin
            fails++;
            $display("FAIL miss_err1: got ready=%b resp=%b rdata=%h, expected 0 01 0",
                     m_hready, m_hresp, m_hrdata);
        end
        checks++;
        if ({err_cnt, err_addr} !== {exp_cnt, 32'h5000_0000}) begin
            fails++;
            $display("FAIL miss_log: got cnt=%h addr=%h, expected %h 50000000",
                     err_cnt, err_addr, exp_cnt);
        end
        next_cycle();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL miss_err2: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({m_hready, m_hresp} !== 3'b100) begin
            fails++;
            $display("FAIL miss_recover: got ready=%b resp=%b, expected 1 00", m_hready, m_hresp);
        end
    endtask

    task automatic test_idle_unmapped();
        drive(32'h7000_0000, IDLE, 1'b0);
        @(negedge clk);
        drive(32'h7000_0004, BUSY, 1'b0);
        @(negedge clk);
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, 2'b00, 32'h0}) begin
            fails++;
            $display("FAIL idle_unmapped: got ready=%b resp=%b rdata=%h, expected 1 00 0",
                     m_hready, m_hresp, m_hrdata);
        end
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        checks++;
        if ({m_hready, m_hresp, err_cnt} !== {1'b1, 2'b00, exp_cnt}) begin
            fails++;
            $display("FAIL busy_unmapped: got ready=%b resp=%b cnt=%h, expected 1 00 %h",
                     m_hready, m_hresp, err_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h5000_0000, NONSEQ, 1'b0);
        @(negedge clk);
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h6000_0004, NONSEQ, 1'b0);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({m_hready, m_hresp, err_cnt} !== {1'b0, 2'b01, exp_cnt}) begin
            fails++;
            $display("FAIL b2b_err1_a: got ready=%b resp=%b cnt=%h, expected 0 01 %h",
                     m_hready, m_hresp, err_cnt, exp_cnt);
        end
        next_cycle();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL b2b_err2_a: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h2000_0008, NONSEQ, 1'b0);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({m_hready, m_hresp, err_cnt, err_addr} !== {1'b0, 2'b01, exp_cnt, 32'h6000_0004}) begin
            fails++;
            $display("FAIL b2b_err1_b: got ready=%b resp=%b cnt=%h addr=%h, expected 0 01 %h 60000004",
                     m_hready, m_hresp, err_cnt, err_addr, exp_cnt);
        end
        next_cycle();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL b2b_err2_b: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata, err_cnt} !== {1'b1, e.resp, e.rdata, exp_cnt}) begin
            fails++;
            $display("FAIL b2b_hit_after_err: got ready=%b resp=%b rdata=%h cnt=%h, expected 1 %b %h %h",
                     m_hready, m_hresp, m_hrdata, err_cnt, e.resp, e.rdata, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        dut.err_cnt_q = 16'hFFFE;
        drive(32'h8000_0000, NONSEQ, 1'b0);
        @(negedge clk);
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h9000_0000, NONSEQ, 1'b0);
        @(negedge clk);
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_reach: got cnt=%h, expected ffff", err_cnt);
        end
        next_cycle();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL sat_err2: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        checks++;
        if ({err_cnt, err_addr} !== {16'hFFFF, 32'h9000_0000}) begin
            fails++;
            $display("FAIL sat_hold: got cnt=%h addr=%h, expected ffff 90000000", err_cnt, err_addr);
        end
        next_cycle();
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata} !== {1'b1, e.resp, e.rdata}) begin
            fails++;
            $display("FAIL sat_err2_b: got ready=%b resp=%b rdata=%h, expected 1 %b %h",
                     m_hready, m_hresp, m_hrdata, e.resp, e.rdata);
        end
        exp_cnt = 16'hFFFF;
    endtask

    task automatic test_reset_mid_err();
        drive(32'hA000_0000, NONSEQ, 1'b0);
        @(negedge clk);
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        checks++;
        if ({m_hready, m_hresp} !== 3'b001) begin
            fails++;
            $display("FAIL pre_reset_err1: got ready=%b resp=%b, expected 0 01", m_hready, m_hresp);
        end
        #1 rst_n = 1'b0;
        #1;
        // Reset wipes the in-flight ERROR phase, so its queued expectation is dropped.
        exp_q.delete();
        exp_cnt = 16'h0;
        checks++;
        if ({m_hready, m_hresp, m_hrdata, err_cnt, err_addr} !== {1'b1, 2'b00, 32'h0, exp_cnt, 32'h0}) begin
            fails++;
            $display("FAIL async_reset: got ready=%b resp=%b rdata=%h cnt=%h addr=%h, expected 1 00 0 0 0",
                     m_hready, m_hresp, m_hrdata, err_cnt, err_addr);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0000_0100, NONSEQ, 1'b0);
        @(negedge clk);
        checks++;
        if (s_hsel !== 4'b0001) begin
            fails++;
            $display("FAIL resume_hsel: got %b, expected 0001", s_hsel);
        end
        exp_q.push_back(exp_for(m_haddr, m_htrans));
        drive(32'h0, IDLE, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({m_hready, m_hresp, m_hrdata, err_cnt} !== {1'b1, e.resp, e.rdata, exp_cnt}) begin
            fails++;
            $display("FAIL resume_read: got ready=%b resp=%b rdata=%h cnt=%h, expected 1 %b %h %h",
                     m_hready, m_hresp, m_hrdata, err_cnt, e.resp, e.rdata, exp_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        exp_cnt  = 16'h0;
        rst_n    = 1'b0;
        m_haddr  = '0;
        m_htrans = IDLE;
        m_hwrite = 1'b0;
        m_hsize  = 3'b010;
        m_hburst = 3'b000;
        m_hprot  = 4'b0011;
        m_hwdata = '0;
        s_hresp  = '0;
        s_hreadyo = '1;
        for (int i = 0; i < 4; i++) s_hrdata[i*32 +: 32] = slv_data(i);

        test_reset();
        test_read_hit();
        test_wait_states();
        test_miss();
        test_idle_unmapped();
        test_back_to_back();
        test_saturation();
        test_reset_mid_err();

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
